// File: rtl/decode20_pkg.sv
// decode20_pkg: opcodes, ALU controls, instruction field positions and control bundle for the decode stage.
package decode20_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam int OP_HI  = 19;
  localparam int OP_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int RS1_HI = 10;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 1;
  localparam int IMM_HI = 5;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  function automatic ctrl_t rtype(input logic [2:0] alu);
    return '{reg_write: 1'b1, alu_ctrl: alu, default: '0};
  endfunction
endpackage

// File: rtl/register_file_20.sv
// register_file_20: 32-entry register file, x0 hardwired to zero, combinational reads with write-first bypass.
module register_file_20 #(
  parameter int DATA_W = 22,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] regs [2**REG_AW];
  logic              wr_ok;

  assign wr_ok = we && (wa != '0);

  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    else if (wr_ok)
      regs[wa] <= wd;

  // a write landing this cycle is visible to the read in the same cycle
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : (wr_ok && wa == ra1) ? wd : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : (wr_ok && wa == ra2) ? wd : regs[ra2];
  end
endmodule

// File: rtl/decode_cycle_20.sv
// decode_cycle_20: ID stage; decodes the instruction, reads operands, extends the immediate and registers all into ID/EX.
module decode_cycle_20
  import decode20_pkg::*;
#(
  parameter int DATA_W  = 22,
  parameter int INSTR_W = 20,
  parameter int REG_AW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteW,
  input  logic [REG_AW-1:0]  RDW,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [DATA_W-1:0]  PCD,
  input  logic [DATA_W-1:0]  PCPlus4D,
  input  logic [DATA_W-1:0]  ResultW,
  output logic               RegWriteE,
  output logic               ALUSrcE,
  output logic               MemWriteE,
  output logic               ResultSrcE,
  output logic               BranchE,
  output logic [2:0]         ALUControlE,
  output logic [DATA_W-1:0]  RD1_E,
  output logic [DATA_W-1:0]  RD2_E,
  output logic [DATA_W-1:0]  Imm_Ext_E,
  output logic [REG_AW-1:0]  RS1_E,
  output logic [REG_AW-1:0]  RS2_E,
  output logic [REG_AW-1:0]  RD_E,
  output logic [DATA_W-1:0]  PCE,
  output logic [DATA_W-1:0]  PCPlus4E
);
  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2, rd_eff;
  logic [5:0]        imm6;
  logic [DATA_W-1:0] imm_ext, rd1, rd2;
  logic              i_type, s_type;
  ctrl_t             ctrl;

  assign op  = InstrD[OP_HI:OP_LO];
  assign rd  = InstrD[RD_HI:RD_LO];
  assign rs1 = InstrD[RS1_HI:RS1_LO];
  assign rs2 = InstrD[RS2_HI:RS2_LO];

  register_file_20 #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD:  ctrl = rtype(ALU_ADD);
      OP_SUB:  ctrl = rtype(ALU_SUB);
      OP_AND:  ctrl = rtype(ALU_AND);
      OP_OR:   ctrl = rtype(ALU_OR);
      OP_XOR:  ctrl = rtype(ALU_XOR);
      OP_SLT:  ctrl = rtype(ALU_SLT);
      OP_SLL:  ctrl = rtype(ALU_SLL);
      OP_SRL:  ctrl = rtype(ALU_SRL);
      OP_ADDI: ctrl = '{reg_write: 1'b1, alu_src: 1'b1, alu_ctrl: ALU_ADD, default: '0};
      OP_LW:   ctrl = '{reg_write: 1'b1, alu_src: 1'b1, result_src: 1'b1, alu_ctrl: ALU_ADD, default: '0};
      OP_SW:   ctrl = '{alu_src: 1'b1, mem_write: 1'b1, alu_ctrl: ALU_ADD, default: '0};
      OP_BEQ:  ctrl = '{branch: 1'b1, alu_ctrl: ALU_SUB, default: '0};
      default: ctrl = '0;
    endcase
  end

  // stores and branches reuse the rd field as the upper immediate bits
  always_comb begin
    i_type  = (op == OP_ADDI) || (op == OP_LW);
    s_type  = (op == OP_SW) || (op == OP_BEQ);
    imm6    = s_type ? {rd, InstrD[0]} : InstrD[IMM_HI:0];
    imm_ext = (i_type || s_type) ? {{(DATA_W-6){imm6[5]}}, imm6} : '0;
    rd_eff  = s_type ? '0 : rd;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      RS1_E       <= '0;
      RS2_E       <= '0;
      RD_E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= ctrl.reg_write;
      ALUSrcE     <= ctrl.alu_src;
      MemWriteE   <= ctrl.mem_write;
      ResultSrcE  <= ctrl.result_src;
      BranchE     <= ctrl.branch;
      ALUControlE <= ctrl.alu_ctrl;
      RD1_E       <= rd1;
      RD2_E       <= rd2;
      Imm_Ext_E   <= imm_ext;
      RS1_E       <= rs1;
      RS2_E       <= rs2;
      RD_E        <= rd_eff;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
endmodule

// File: tb/tb_decode_cycle_20.sv
// tb_decode_cycle_20: table-driven directed vectors plus reset sequences for the ID stage.
module tb_decode_cycle_20;
  logic        clk = 1'b0, rst = 1'b0, RegWriteW = 1'b0;
  logic [4:0]  RDW = '0;
  logic [19:0] InstrD = '0;
  logic [21:0] PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [21:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RS1_E, RS2_E, RD_E;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [21:0] rd1, rd2, imm;
    logic [4:0]  s1, s2, d;
    logic [21:0] pc, pc4;
  } out_t;

  typedef struct {
    logic        we;
    logic [4:0]  rdw;
    logic [21:0] res;
    logic [19:0] ins;
    out_t        exp;
  } vec_t;

  int   passed = 0, total = 0;
  out_t act, e;
  vec_t tbl[$];

  decode_cycle_20 dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RDW(RDW), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  assign act = {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E};

  task automatic check(input string name, input out_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ctl = {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}
  function automatic vec_t v(input logic we, input logic [4:0] rdw, input logic [21:0] res,
                             input logic [3:0] op, input logic [4:0] rd, s1, s2, input logic b0,
                             input logic [7:0] ctl, input logic [21:0] r1, r2, im, input logic [4:0] d);
    vec_t t;
    t.we  = we;
    t.rdw = rdw;
    t.res = res;
    t.ins = {op, rd, s1, s2, b0};
    t.exp = {ctl, r1, r2, im, s1, s2, d, 22'd0, 22'd0};
    return t;
  endfunction

  initial begin
    tbl.push_back(v(1, 5'd1,  22'h0000F, 4'h0,  5'd0,  5'd0,  5'd0,  0, 8'h00, 22'h0,      22'h0,      22'h0,      5'd0));
    tbl.push_back(v(1, 5'd2,  22'h00005, 4'h0,  5'd0,  5'd0,  5'd0,  0, 8'h00, 22'h0,      22'h0,      22'h0,      5'd0));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h1,  5'd3,  5'd1,  5'd2,  0, 8'h80, 22'h0000F,  22'h00005,  22'h0,      5'd3));
    tbl.push_back(v(1, 5'd1,  22'h3FFFF, 4'h1,  5'd4,  5'd1,  5'd2,  0, 8'h80, 22'h3FFFF,  22'h00005,  22'h0,      5'd4));
    tbl.push_back(v(1, 5'd0,  22'h12345, 4'h1,  5'd5,  5'd0,  5'd1,  0, 8'h80, 22'h0,      22'h3FFFF,  22'h0,      5'd5));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h2,  5'd6,  5'd2,  5'd1,  0, 8'h81, 22'h00005,  22'h3FFFF,  22'h0,      5'd6));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h9,  5'd7,  5'd1,  5'd31, 0, 8'hC0, 22'h3FFFF,  22'h0,      22'h3FFFFE, 5'd7));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'hA,  5'd8,  5'd2,  5'd2,  1, 8'hD0, 22'h00005,  22'h00005,  22'h00005,  5'd8));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'hB,  5'd1,  5'd2,  5'd1,  1, 8'h60, 22'h00005,  22'h3FFFF,  22'h00003,  5'd0));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'hC,  5'd30, 5'd1,  5'd2,  0, 8'h09, 22'h3FFFF,  22'h00005,  22'h3FFFFC, 5'd0));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'hF,  5'd9,  5'd1,  5'd2,  1, 8'h00, 22'h3FFFF,  22'h00005,  22'h0,      5'd9));
    tbl.push_back(v(1, 5'd10, 22'h2AAAA, 4'h4,  5'd11, 5'd10, 5'd10, 0, 8'h83, 22'h2AAAA,  22'h2AAAA,  22'h0,      5'd11));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h7,  5'd12, 5'd10, 5'd1,  0, 8'h86, 22'h2AAAA,  22'h3FFFF,  22'h0,      5'd12));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h3,  5'd13, 5'd1,  5'd2,  0, 8'h82, 22'h3FFFF,  22'h00005,  22'h0,      5'd13));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h5,  5'd14, 5'd2,  5'd10, 0, 8'h84, 22'h00005,  22'h2AAAA,  22'h0,      5'd14));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h6,  5'd15, 5'd1,  5'd1,  0, 8'h85, 22'h3FFFF,  22'h3FFFF,  22'h0,      5'd15));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h8,  5'd16, 5'd2,  5'd2,  0, 8'h87, 22'h00005,  22'h00005,  22'h0,      5'd16));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'h0,  5'd17, 5'd1,  5'd2,  1, 8'h00, 22'h3FFFF,  22'h00005,  22'h0,      5'd17));
    tbl.push_back(v(0, 5'd0,  22'h0,     4'hD,  5'd18, 5'd2,  5'd1,  0, 8'h00, 22'h00005,  22'h3FFFF,  22'h0,      5'd18));

    // held in reset with random traffic: outputs stay a bubble
    repeat (3) begin
      @(negedge clk);
      InstrD    = 20'($urandom);
      PCD       = 22'($urandom);
      PCPlus4D  = 22'($urandom);
      RegWriteW = 1'b1;
      RDW       = 5'($urandom);
      ResultW   = 22'($urandom);
      @(negedge clk);
      check("reset_hold", '0);
    end

    // first edge after release captures the current instruction
    RegWriteW = 1'b0;
    InstrD    = {4'h1, 5'd3, 5'd0, 5'd0, 1'b0};
    PCD       = 22'h001A0;
    PCPlus4D  = 22'h001A4;
    rst       = 1'b1;
    #1 check("release_pre_edge", '0);
    @(posedge clk);
    @(negedge clk);
    check("release_capture", {8'h80, 22'h0, 22'h0, 22'h0, 5'd0, 5'd0, 5'd3, 22'h001A0, 22'h001A4});

    for (int i = 0; i < tbl.size(); i++) begin
      RegWriteW = tbl[i].we;
      RDW       = tbl[i].rdw;
      ResultW   = tbl[i].res;
      InstrD    = tbl[i].ins;
      PCD       = 22'h00200 + 22'(i * 8);
      PCPlus4D  = PCD + 22'd4;
      e         = tbl[i].exp;
      e.pc      = PCD;
      e.pc4     = PCPlus4D;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), e);
    end

    // asynchronous reset mid-cycle clears outputs and the register file
    RegWriteW = 1'b0;
    InstrD    = {4'h1, 5'd3, 5'd1, 5'd2, 1'b0};
    PCD       = 22'h0001A;
    PCPlus4D  = 22'h0001E;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", '0);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("regs_cleared", {8'h80, 22'h0, 22'h0, 22'h0, 5'd1, 5'd2, 5'd3, 22'h0001A, 22'h0001E});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
